// File: rtl/lab2_pkg.sv
// Shared types and constants for the Lab 2 input conditioning stage.
package lab2_pkg;

    typedef enum logic [1:0] {
        MANUAL = 2'b00,
        AUTO   = 2'b01,
        STEP   = 2'b10
    } mode_e;

    localparam logic [1:0] MODE_RSVD = 2'b11;

    // Packed operand triple, ordered {a,b,c}.
    typedef logic [2:0] abc_t;

endpackage

// File: rtl/lab2_debounce.sv
// One-bit 2-flop synchronizer followed by a stability counter; the output only
// follows the input after it has held a new value for DEBOUNCE_CYCLES cycles.
module lab2_debounce
    import lab2_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_raw,
    output logic d_stable
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Synchronize, then count consecutive cycles the synced value differs from the stable one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            cnt      <= '0;
            d_stable <= 1'b0;
        end else begin
            sync1 <= d_raw;
            sync2 <= sync1;
            if (sync2 == d_stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                d_stable <= sync2;
                cnt      <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/lab2_input_stage.sv
// Input conditioning for the Lab 2 logic block: debounced switches, an
// auto-advancing pattern sweep and a button-stepped pattern, presented as
// registered a/b/c plus a one-cycle update strobe.
//
// state  | meaning
// MANUAL | a/b/c follow the debounced switches, pattern held at 0
// AUTO   | pattern advances every STEP_CYCLES cycles
// STEP   | pattern advances on each debounced button press
module lab2_input_stage
    import lab2_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int STEP_CYCLES     = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] sw,
    input  logic       btn_step,
    input  logic [1:0] mode,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       abc_upd,
    output logic [2:0] pattern
);

    localparam int TW = $clog2(STEP_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(STEP_CYCLES - 1);

    abc_t          sw_stable;
    logic          btn_stable;
    logic          btn_q;
    logic          step_pulse;
    logic [1:0]    mode_s1;
    logic [1:0]    mode_s2;
    mode_e         state;
    mode_e         next_state;
    abc_t          pattern_q;
    logic [TW-1:0] timer;
    abc_t          abc_q;
    abc_t          abc_next;

    lab2_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_a (
        .clk(clk), .rst_n(rst_n), .d_raw(sw[2]), .d_stable(sw_stable[2])
    );
    lab2_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_b (
        .clk(clk), .rst_n(rst_n), .d_raw(sw[1]), .d_stable(sw_stable[1])
    );
    lab2_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_c (
        .clk(clk), .rst_n(rst_n), .d_raw(sw[0]), .d_stable(sw_stable[0])
    );
    lab2_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_btn (
        .clk(clk), .rst_n(rst_n), .d_raw(btn_step), .d_stable(btn_stable)
    );

    // Mode is only synchronized; it is a slow configuration input, not a bouncing contact.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_s1 <= 2'b00;
            mode_s2 <= 2'b00;
        end else begin
            mode_s1 <= mode;
            mode_s2 <= mode_s1;
        end
    end

    // Remember the previous debounced button level for rising-edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_q <= 1'b0;
        end else begin
            btn_q <= btn_stable;
        end
    end

    assign step_pulse = btn_stable & ~btn_q;

    // Decode the synchronized mode; the reserved code behaves as MANUAL.
    always_comb begin
        next_state = MANUAL;
        case (mode_s2)
            2'b01:     next_state = AUTO;
            2'b10:     next_state = STEP;
            MODE_RSVD: next_state = MANUAL;
            default:   next_state = MANUAL;
        endcase
    end

    // Mode FSM with timer and pattern counter; a mode change outranks any advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= MANUAL;
            pattern_q <= '0;
            timer     <= '0;
        end else if (next_state != state) begin
            state     <= next_state;
            pattern_q <= '0;
            timer     <= '0;
        end else begin
            case (state)
                AUTO: begin
                    if (timer == TIMER_LAST) begin
                        timer     <= '0;
                        pattern_q <= pattern_q + 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                STEP: begin
                    timer <= '0;
                    if (step_pulse) begin
                        pattern_q <= pattern_q + 1'b1;
                    end
                end
                default: begin
                    timer     <= '0;
                    pattern_q <= '0;
                end
            endcase
        end
    end

    assign abc_next = (state == MANUAL) ? sw_stable : pattern_q;

    // Output register; the strobe fires whenever the registered triple changes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            abc_q   <= '0;
            abc_upd <= 1'b0;
        end else begin
            abc_q   <= abc_next;
            abc_upd <= (abc_next != abc_q);
        end
    end

    assign a       = abc_q[2];
    assign b       = abc_q[1];
    assign c       = abc_q[0];
    assign pattern = pattern_q;

endmodule

// File: doc/lab2_input_stage.md
# lab2_input_stage

Input conditioning stage that drives the `a`, `b`, `c` operands of the Lab 2 combinational logic block. It debounces three slide switches and a step push-button, and it supports three source modes: live switches, a free-running 3-bit pattern sweep, and a button-stepped pattern. It presents registered `a`, `b`, `c` together with a one-cycle update strobe, so the downstream logic and its LEDs see glitch-free, exhaustively sweepable inputs.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: cycles an input must stay stable before it is accepted; must be ≥2.
- `STEP_CYCLES`, default 50_000_000: cycles between pattern advances in AUTO mode; must be ≥2.
- `clk`  in  1  single system clock; all logic is on its rising edge.
- `rst_n`  in  1  reset; synchronous and active-low.
- `sw`  in  3  raw slide switches; `sw[2]`→a, `sw[1]`→b, `sw[0]`→c. Asynchronous to `clk`.
- `btn_step`  in  1  raw step push-button; asynchronous to `clk`.
- `mode`  in  2  source select: 00 MANUAL, 01 AUTO, 10 STEP, 11 reserved (treated as MANUAL).
- `a`, `b`, `c`  out  1 each  registered operands for the downstream block.
- `abc_upd`  out  1  one-cycle pulse in the same cycle that any of `a`/`b`/`c` takes a new value.
- `pattern`  out  3  current sweep index {a,b,c} while in AUTO or STEP; 0 in MANUAL.

## Operation
- **Synchronizers:** each of `sw[2:0]`, `btn_step` and `mode[1:0]` passes through a 2-flop synchronizer. `mode` is synchronized but not debounced.
- **Debounce (per bit):**
  - Counter width is `$clog2(DEBOUNCE_CYCLES)`.
  - If the synchronized value equals the stable value, the counter clears.
  - Otherwise the counter increments. When it reaches `DEBOUNCE_CYCLES-1` while the values still differ, the stable value takes the synchronized value and the counter clears.
  - A bounce shorter than `DEBOUNCE_CYCLES` is never accepted.
- **Step-button edge detect:** a rising edge of the debounced button yields a one-cycle `step_pulse`.
- **Mode FSM:** states are MANUAL, AUTO and STEP, selected directly by the synchronized `mode`.
  - MANUAL: the next `{a,b,c}` equals the debounced switches.
  - AUTO: a timer counts 0..`STEP_CYCLES-1`. At terminal count the timer returns to 0 and `pattern` increments.
  - STEP: `pattern` increments on each `step_pulse`. The timer is held at 0.
  - `pattern` wraps from 3'b111 to 3'b000, modulo 8 with no carry out.
  - Any state change clears `pattern` and the timer to 0 on the transition edge.
- **Simultaneous events:** a mode change on the same edge as a terminal count or `step_pulse` wins; `pattern` goes to 0, not +1. A button edge in AUTO or MANUAL is discarded.
- **`abc_upd`:** asserted iff the registered `{a,b,c}` differs from its previous value. Entering AUTO from MANUAL with switches ≠ 000 therefore produces one pulse.

## Timing
- **Reset** (`rst_n` low at a rising edge):
  - `a`=`b`=`c`=0, `abc_upd`=0, `pattern`=0.
  - FSM = MANUAL.
  - All synchronizer, debounce, stable and timer registers = 0.
  - Reset mid-debounce or mid-sweep discards the partial count.
- **Switch latency:** with `sw` constant from sampling edge k, the new value reaches `a`/`b`/`c` (with `abc_upd`=1) at edge k+`DEBOUNCE_CYCLES`+2.
- **AUTO:** `{a,b,c}` follows `pattern` with 1 register cycle of latency. It advances every `STEP_CYCLES` cycles, so a full 8-pattern sweep is 8×`STEP_CYCLES`.
- **STEP:** `a`/`b`/`c` change 2 cycles after the debounced button's rising edge (edge detect, then output register).
- **Mode change latency:** 2 synchronizer cycles, 1 FSM cycle, then 1 output cycle.

## Structure
- **Shared package `lab2_pkg`:**
  - `mode_e` enum (MANUAL=2'b00, AUTO=2'b01, STEP=2'b10).
  - `MODE_RSVD` constant.
  - `abc_t` typedef, a 3-bit packed {a,b,c}.
- **Sub-module `lab2_debounce`:** 1-bit 2-flop synchronizer plus stable counter, parameterized by `DEBOUNCE_CYCLES`. It has ports `clk`, `rst_n`, `d_raw`, `d_stable` and is instantiated four times (3 switches, 1 button).
- **Top-level:** mode FSM, timer, pattern counter, edge detect, output registers.

## Test plan
Bench parameters are `DEBOUNCE_CYCLES`=4 and `STEP_CYCLES`=3.
- Reset: hold `rst_n`=0 for 3 cycles with `sw`=3'b101 → `a`=`b`=`c`=0, `abc_upd`=0, `pattern`=0; after release, `{a,b,c}`=101 with a single `abc_upd` at edge 6.
- Bounce: in MANUAL, toggle `sw[1]` 0→1→0→1 with 2-cycle high/low intervals, then hold 1 → `b` rises exactly once, 6 edges after the final transition, with exactly one `abc_upd`.
- AUTO sweep: set `mode`=01 from MANUAL with `sw`=000 → `pattern` runs 0,1,…,7,0 with 3 cycles per value; `abc_upd` pulses on every change; the wrap 111→000 is checked.
- STEP: set `mode`=10 and give 9 clean button presses, each 6 cycles high and 6 low → `{a,b,c}` goes 001…111,000,001; presses made in AUTO are ignored.
- Collision: switch `mode` 01→10 on the same synchronized edge as an AUTO terminal count → `pattern`=0, not incremented.
- Reserved mode: set `mode`=11 with `sw`=110 → behaviour is identical to MANUAL, `{a,b,c}`=110, `pattern`=0.
